// File: rtl/heater_ctrl.sv
// heater_ctrl: sequences N heater enables up/down one step at a time,
// latches per-heater errors, shuts everything down on a fault and pulses
// heater_err_clear until the latched errors go away.
module heater_ctrl #(
    parameter int  N            = 16,
    parameter int  STEP_CYCLES  = 1024,
    parameter int  CLEAR_CYCLES = 16,
    localparam int CW           = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic [CW-1:0] target_count,
    input  logic [N-1:0]  heater_error,
    output logic [N-1:0]  heater_enable,
    output logic [N-1:0]  heater_err_clear,
    output logic [CW-1:0] active_count,
    output logic [N-1:0]  err_latched,
    output logic          busy,
    output logic          fault
);

    localparam int STW = $clog2(STEP_CYCLES + 1);
    localparam int CTW = $clog2(CLEAR_CYCLES + 1);
    localparam int WTW = 12;

    localparam logic [STW-1:0] STEP_LAST  = STW'(STEP_CYCLES - 1);
    localparam logic [CTW-1:0] CLEAR_LAST = CTW'(CLEAR_CYCLES - 1);
    localparam logic [WTW-1:0] WAIT_LAST  = 12'd4095;
    localparam logic [CW-1:0]  N_CW       = CW'(N);

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_RAMP_UP     = 3'd1;
    localparam logic [2:0] S_HOLD        = 3'd2;
    localparam logic [2:0] S_RAMP_DOWN   = 3'd3;
    localparam logic [2:0] S_FAULT_CLEAR = 3'd4;
    localparam logic [2:0] S_FAULT_WAIT  = 3'd5;

    logic [2:0]     state, state_d;
    logic [STW-1:0] step_timer, step_timer_d;
    logic [CTW-1:0] clear_timer, clear_timer_d;
    logic [WTW-1:0] wait_timer, wait_timer_d;
    logic           stop_flag, stop_flag_d;
    logic [CW-1:0]  active_count_d;
    logic [N-1:0]   heater_enable_d;
    logic [N-1:0]   heater_err_clear_d;
    logic [N-1:0]   err_latched_d;
    logic           fault_d;

    logic [N-1:0]   err_hit;
    logic [CW-1:0]  tgt_sat;
    logic [CW-1:0]  tgt_eff;
    logic [CW-1:0]  cnt_dn;
    logic           stopping;
    logic           step_wrap;

    // Enables are always the contiguous low block [count-1:0].
    function automatic logic [N-1:0] therm(input logic [CW-1:0] count);
        logic [N-1:0] mask;
        mask = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (i < int'(count));
        end
        return mask;
    endfunction

    // Next-state and next-output computation for the whole controller.
    always_comb begin
        // NOTE: every signal gets a default at the top so no path through the case can infer a latch.
        state_d            = state;
        step_timer_d       = step_timer;
        clear_timer_d      = clear_timer;
        wait_timer_d       = wait_timer;
        stop_flag_d        = stop_flag;
        active_count_d     = active_count;
        heater_err_clear_d = heater_err_clear;
        err_latched_d      = err_latched;
        fault_d            = fault;
        cnt_dn             = active_count - 1'b1;

        err_hit   = heater_error & heater_enable;
        tgt_sat   = (target_count > N_CW) ? N_CW : target_count;
        stopping  = stop_flag || stop;
        tgt_eff   = stopping ? '0 : tgt_sat;
        step_wrap = (step_timer == STEP_LAST);

        if (|err_hit) begin
            // Error on an enabled heater wins over start, stop and steps.
            err_latched_d      = err_latched | err_hit;
            heater_err_clear_d = err_latched | err_hit;
            active_count_d     = '0;
            fault_d            = 1'b1;
            stop_flag_d        = 1'b0;
            state_d            = S_FAULT_CLEAR;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        err_latched_d = '0;
                        stop_flag_d   = 1'b0;
                        state_d       = S_RAMP_UP;
                    end
                end

                S_RAMP_UP: begin
                    if (stop) begin
                        stop_flag_d = 1'b1;
                        state_d     = S_RAMP_DOWN;
                    end else if (step_wrap) begin
                        step_timer_d = '0;
                        if (active_count < tgt_eff) begin
                            active_count_d = active_count + 1'b1;
                        end else if (active_count == tgt_eff) begin
                            state_d = S_HOLD;
                        end else begin
                            state_d = S_RAMP_DOWN;
                        end
                    end else begin
                        step_timer_d = step_timer + 1'b1;
                    end
                end

                S_HOLD: begin
                    if (stopping) begin
                        stop_flag_d = 1'b1;
                        state_d     = S_RAMP_DOWN;
                    end else if (tgt_eff > active_count) begin
                        state_d = S_RAMP_UP;
                    end else if (tgt_eff < active_count) begin
                        state_d = S_RAMP_DOWN;
                    end
                end

                S_RAMP_DOWN: begin
                    if (stop) begin
                        stop_flag_d = 1'b1;
                    end
                    if (step_wrap) begin
                        step_timer_d = '0;
                        if (active_count > tgt_eff) begin
                            active_count_d = cnt_dn;
                            if (cnt_dn == tgt_eff) begin
                                state_d = stopping ? S_IDLE : S_HOLD;
                            end
                        end else if (active_count == tgt_eff) begin
                            state_d = stopping ? S_IDLE : S_HOLD;
                        end else begin
                            state_d = S_RAMP_UP;
                        end
                        if (state_d == S_IDLE) begin
                            stop_flag_d = 1'b0;
                        end
                    end else begin
                        step_timer_d = step_timer + 1'b1;
                    end
                end

                S_FAULT_CLEAR: begin
                    if (clear_timer == CLEAR_LAST) begin
                        heater_err_clear_d = '0;
                        state_d            = S_FAULT_WAIT;
                    end else begin
                        clear_timer_d = clear_timer + 1'b1;
                    end
                end

                S_FAULT_WAIT: begin
                    if ((heater_error & err_latched) == '0) begin
                        fault_d = 1'b0;
                        state_d = S_IDLE;
                    end else if (wait_timer == WAIT_LAST) begin
                        heater_err_clear_d = err_latched;
                        state_d            = S_FAULT_CLEAR;
                    end else begin
                        wait_timer_d = wait_timer + 1'b1;
                    end
                end

                default: begin
                    active_count_d     = '0;
                    heater_err_clear_d = '0;
                    fault_d            = 1'b0;
                    stop_flag_d        = 1'b0;
                    state_d            = S_IDLE;
                end
            endcase
        end

        // Every state entry starts its timers from zero.
        if (state_d != state) begin
            step_timer_d  = '0;
            clear_timer_d = '0;
            wait_timer_d  = '0;
        end

        heater_enable_d = therm(active_count_d);
    end

    // State, timers and all outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            step_timer       <= '0;
            clear_timer      <= '0;
            wait_timer       <= '0;
            stop_flag        <= 1'b0;
            active_count     <= '0;
            heater_enable    <= '0;
            heater_err_clear <= '0;
            err_latched      <= '0;
            fault            <= 1'b0;
            busy             <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments; the combinational block above uses blocking.
            state            <= state_d;
            step_timer       <= step_timer_d;
            clear_timer      <= clear_timer_d;
            wait_timer       <= wait_timer_d;
            stop_flag        <= stop_flag_d;
            active_count     <= active_count_d;
            heater_enable    <= heater_enable_d;
            heater_err_clear <= heater_err_clear_d;
            err_latched      <= err_latched_d;
            fault            <= fault_d;
            busy             <= (state_d != S_IDLE);
        end
    end

endmodule

// File: tb/tb_heater_ctrl.sv
// Self-checking bench for heater_ctrl: a scoreboard of expected
// heater_enable changes (value and cycle), plus per-scenario inline checks.
module tb_heater_ctrl;

    localparam int N    = 16;
    localparam int STEP = 8;
    localparam int CLR  = 4;
    localparam int CW   = $clog2(N + 1);

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          stop  = 1'b0;
    logic [CW-1:0] target_count = '0;
    logic [N-1:0]  heater_error = '0;
    logic [N-1:0]  heater_enable;
    logic [N-1:0]  heater_err_clear;
    logic [CW-1:0] active_count;
    logic [N-1:0]  err_latched;
    logic          busy;
    logic          fault;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int           at;
        logic [N-1:0] en;
        string        tag;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    logic [N-1:0] prev_en = '0;

    heater_ctrl #(
        .N            (N),
        .STEP_CYCLES  (STEP),
        .CLEAR_CYCLES (CLR)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .stop             (stop),
        .target_count     (target_count),
        .heater_error     (heater_error),
        .heater_enable    (heater_enable),
        .heater_err_clear (heater_err_clear),
        .active_count     (active_count),
        .err_latched      (err_latched),
        .busy             (busy),
        .fault            (fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every change of heater_enable must match the next expected entry.
    always @(negedge clk) begin
        if (heater_enable !== prev_en) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL enable_unexpected: got %h at cycle %0d, expected no change", heater_enable, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (heater_enable !== mon_e.en || cyc != mon_e.at) begin
                    n_fail++;
                    $display("FAIL enable_%s: got %h at cycle %0d, expected %h at cycle %0d",
                             mon_e.tag, heater_enable, cyc, mon_e.en, mon_e.at);
                end
            end
            prev_en = heater_enable;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [N-1:0] mask_of(input int c);
        logic [63:0] m;
        m = (64'd1 << c) - 64'd1;
        return m[N-1:0];
    endfunction

    task automatic push_exp(input int at, input logic [N-1:0] en, input string tag);
        exp_t e;
        e.at  = at;
        e.en  = en;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // One expected enable change per step, STEP cycles apart, from the entry edge t0.
    task automatic expect_ramp(input int t0, input int from_cnt, input int to_cnt, input string tag);
        int n;
        int c;
        n = (to_cnt > from_cnt) ? to_cnt - from_cnt : from_cnt - to_cnt;
        for (int k = 1; k <= n; k++) begin
            c = (to_cnt > from_cnt) ? from_cnt + k : from_cnt - k;
            push_exp(t0 + STEP * k, mask_of(c), tag);
        end
    endtask

    // Pulse helpers: called at a negedge, return the cycle of the sampling edge.
    task automatic pulse_start(output int t);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = cyc;
    endtask

    task automatic pulse_stop(output int t);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        t = cyc;
    endtask

    task automatic set_target(input int v, output int t);
        target_count = CW'(v);
        @(negedge clk);
        t = cyc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (heater_enable !== '0) begin n_fail++; $display("FAIL reset_enable: got %h, expected 0", heater_enable); end
        n_checks++;
        if (heater_err_clear !== '0) begin n_fail++; $display("FAIL reset_err_clear: got %h, expected 0", heater_err_clear); end
        n_checks++;
        if (active_count !== '0) begin n_fail++; $display("FAIL reset_active_count: got %0d, expected 0", active_count); end
        n_checks++;
        if (err_latched !== '0) begin n_fail++; $display("FAIL reset_err_latched: got %h, expected 0", err_latched); end
        n_checks++;
        if (busy !== 1'b0 || fault !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy_fault: got busy=%b fault=%b, expected 0 0", busy, fault);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ramp_up();
        int t;
        target_count = 4;
        pulse_start(t);
        expect_ramp(t, 0, 4, "ramp_up");
        repeat (STEP * 5 + 2) @(negedge clk);
        n_checks++;
        if (active_count !== 4 || heater_enable !== 16'h000F) begin
            n_fail++; $display("FAIL ramp_hold: got count=%0d enable=%h, expected 4 000f", active_count, heater_enable);
        end
        n_checks++;
        if (busy !== 1'b1 || fault !== 1'b0) begin
            n_fail++; $display("FAIL ramp_busy: got busy=%b fault=%b, expected 1 0", busy, fault);
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL ramp_pending: got %0d pending, expected 0", exp_q.size()); end
    endtask

    task automatic test_retarget_stop();
        int t;
        set_target(2, t);
        expect_ramp(t, 4, 2, "retarget");
        repeat (STEP * 2 + 2) @(negedge clk);
        n_checks++;
        if (active_count !== 2 || busy !== 1'b1) begin
            n_fail++; $display("FAIL retarget_hold: got count=%0d busy=%b, expected 2 1", active_count, busy);
        end
        pulse_stop(t);
        expect_ramp(t, 2, 0, "stop");
        repeat (STEP * 2 - 1) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL stop_busy_before: got %b, expected 1", busy); end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || active_count !== 0) begin
            n_fail++; $display("FAIL stop_idle: got busy=%b count=%0d, expected 0 0", busy, active_count);
        end
        // stop in IDLE does nothing
        pulse_stop(t);
        repeat (STEP * 2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL stop_in_idle: got busy=%b pending=%0d, expected 0 0", busy, exp_q.size());
        end
    endtask

    task automatic test_saturation();
        int t;
        target_count = 31;
        pulse_start(t);
        expect_ramp(t, 0, N, "saturate_up");
        repeat (STEP * (N + 1) + 2) @(negedge clk);
        n_checks++;
        if (active_count !== N || heater_enable !== 16'hFFFF || busy !== 1'b1) begin
            n_fail++; $display("FAIL saturate_hold: got count=%0d enable=%h busy=%b, expected 16 ffff 1",
                               active_count, heater_enable, busy);
        end
        pulse_stop(t);
        expect_ramp(t, N, 0, "saturate_down");
        repeat (STEP * N + 2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL saturate_idle: got busy=%b pending=%0d, expected 0 0", busy, exp_q.size());
        end
    endtask

    task automatic test_fault();
        int t;
        int f;
        int n_high;
        int bad_val;
        int fault_fall;
        target_count = 4;
        pulse_start(t);
        expect_ramp(t, 0, 4, "fault_ramp");
        repeat (STEP * 5 + 2) @(negedge clk);
        heater_error = 16'h0004;
        f = cyc;
        push_exp(f + 1, '0, "fault_shutdown");
        @(negedge clk);
        n_checks++;
        if (fault !== 1'b1 || active_count !== 0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL fault_entry: got fault=%b count=%0d busy=%b, expected 1 0 1", fault, active_count, busy);
        end
        n_checks++;
        if (err_latched !== 16'h0004 || heater_err_clear !== 16'h0004) begin
            n_fail++; $display("FAIL fault_latch: got latched=%h clear=%h, expected 0004 0004", err_latched, heater_err_clear);
        end
        n_high     = (heater_err_clear !== '0) ? 1 : 0;
        bad_val    = 0;
        fault_fall = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cyc == f + 5) heater_error = '0;
            if (heater_err_clear !== '0) begin
                n_high++;
                if (heater_err_clear !== 16'h0004) bad_val++;
            end
            if (fault === 1'b0 && fault_fall < 0) fault_fall = cyc;
        end
        n_checks++;
        if (n_high != CLR || bad_val != 0) begin
            n_fail++; $display("FAIL clear_pulse: got %0d cycles (%0d bad), expected %0d cycles of 0004", n_high, bad_val, CLR);
        end
        n_checks++;
        if (fault_fall != f + 6) begin
            n_fail++; $display("FAIL fault_recover: got fault low at cycle %0d, expected %0d", fault_fall, f + 6);
        end
        n_checks++;
        if (busy !== 1'b0 || err_latched !== 16'h0004 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL fault_idle: got busy=%b latched=%h pending=%0d, expected 0 0004 0",
                               busy, err_latched, exp_q.size());
        end
    endtask

    task automatic test_masked_priority();
        int t;
        int f;
        target_count = 4;
        pulse_start(t);
        n_checks++;
        if (err_latched !== '0) begin n_fail++; $display("FAIL start_clears_latch: got %h, expected 0", err_latched); end
        expect_ramp(t, 0, 4, "masked_ramp");
        repeat (STEP * 5 + 2) @(negedge clk);
        heater_error = 16'h0200;
        repeat (10) @(negedge clk);
        n_checks++;
        if (fault !== 1'b0 || err_latched !== '0 || active_count !== 4 || heater_err_clear !== '0) begin
            n_fail++; $display("FAIL masked_error: got fault=%b latched=%h count=%0d clear=%h, expected 0 0000 4 0000",
                               fault, err_latched, active_count, heater_err_clear);
        end
        heater_error = 16'h0008;
        stop         = 1'b1;
        f            = cyc;
        push_exp(f + 1, '0, "err_stop_shutdown");
        @(negedge clk);
        heater_error = '0;
        stop         = 1'b0;
        n_checks++;
        if (fault !== 1'b1 || err_latched !== 16'h0008 || heater_err_clear !== 16'h0008) begin
            n_fail++; $display("FAIL err_beats_stop: got fault=%b latched=%h clear=%h, expected 1 0008 0008",
                               fault, err_latched, heater_err_clear);
        end
        repeat (CLR + 4) @(negedge clk);
        n_checks++;
        if (fault !== 1'b0 || busy !== 1'b0 || err_latched !== 16'h0008 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL err_stop_idle: got fault=%b busy=%b latched=%h pending=%0d, expected 0 0 0008 0",
                               fault, busy, err_latched, exp_q.size());
        end
    endtask

    task automatic test_retry_reset();
        int t;
        int f;
        int rise1;
        int rise2;
        int fault_drop;
        bit prev_clr;
        target_count = 4;
        pulse_start(t);
        expect_ramp(t, 0, 4, "retry_ramp");
        repeat (STEP * 5 + 2) @(negedge clk);
        heater_error = 16'h0004;
        f = cyc;
        push_exp(f + 1, '0, "retry_shutdown");
        rise1      = -1;
        rise2      = -1;
        fault_drop = 0;
        prev_clr   = 1'b0;
        for (int i = 0; i < 4200 && rise2 < 0; i++) begin
            @(negedge clk);
            if (heater_err_clear !== '0 && !prev_clr) begin
                if (rise1 < 0) rise1 = cyc;
                else           rise2 = cyc;
            end
            prev_clr = (heater_err_clear !== '0);
            if (fault !== 1'b1) fault_drop++;
        end
        n_checks++;
        if (rise1 != f + 1) begin n_fail++; $display("FAIL retry_first: got rise at %0d, expected %0d", rise1, f + 1); end
        n_checks++;
        if (rise2 - rise1 != CLR + 4096) begin
            n_fail++; $display("FAIL retry_gap: got %0d cycles between pulses, expected %0d", rise2 - rise1, CLR + 4096);
        end
        n_checks++;
        if (fault_drop != 0 || heater_err_clear !== 16'h0004) begin
            n_fail++; $display("FAIL retry_state: got fault_drops=%0d clear=%h, expected 0 0004", fault_drop, heater_err_clear);
        end
        // asynchronous reset in the middle of the err_clear pulse
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if (heater_err_clear !== '0 || fault !== 1'b0 || err_latched !== '0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_clear: got clear=%h fault=%b latched=%h busy=%b, expected 0 0 0 0",
                               heater_err_clear, fault, err_latched, busy);
        end
        heater_error = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || fault !== 1'b0 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL reset_in_clear_after: got busy=%b fault=%b pending=%0d, expected 0 0 0",
                               busy, fault, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_ramp();
        int t;
        target_count = 4;
        pulse_start(t);
        push_exp(t + STEP, 16'h0001, "reset_ramp");
        push_exp(t + 2 * STEP, 16'h0003, "reset_ramp");
        repeat (2 * STEP + 4) @(negedge clk);
        push_exp(cyc + 1, '0, "reset_clear");
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if (heater_enable !== '0 || active_count !== '0 || busy !== 1'b0 || fault !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_ramp: got enable=%h count=%0d busy=%b fault=%b, expected 0 0 0 0",
                               heater_enable, active_count, busy, fault);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3 * STEP) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || heater_enable !== '0 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL reset_stays_idle: got busy=%b enable=%h pending=%0d, expected 0 0 0",
                               busy, heater_enable, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_retarget_stop();
        test_saturation();
        test_fault();
        test_masked_priority();
        test_retry_reset();
        test_reset_mid_ramp();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
